// File: rtl/stump_pkg.sv
// -----------------------------------------------------------------------------
// stump_pkg
// Shared constants for the Stump register bank slice.
//   DATA_W   : register / datapath width
//   ADDR_W   : register address width (2**ADDR_W registers)
//   REG_ZERO : index of the hard-wired zero register
//   REG_PC   : index of the program counter register
//   RESET_PC : default value loaded into the PC on reset
// -----------------------------------------------------------------------------
package stump_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    localparam logic [2:0] REG_ZERO = 3'd0;
    localparam logic [2:0] REG_PC   = 3'd7;

    localparam logic [DATA_W-1:0] RESET_PC = 16'h0000;

endpackage

// File: rtl/stump_reg_bank_if.sv
// -----------------------------------------------------------------------------
// stump_reg_bank_if
// Bundle of the register bank's write port, fetch increment, three read ports
// and the PC output.
//   master : control/datapath side (drives addresses, write data, strobes)
//   slave  : register bank side (returns read data and pc_out)
// -----------------------------------------------------------------------------
interface stump_reg_bank_if;
    import stump_pkg::*;

    logic              write_en;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              pc_inc;
    logic [ADDR_W-1:0] read_addr_A;
    logic [ADDR_W-1:0] read_addr_B;
    logic [ADDR_W-1:0] read_addr_C;
    logic [DATA_W-1:0] read_data_A;
    logic [DATA_W-1:0] read_data_B;
    logic [DATA_W-1:0] read_data_C;
    logic [DATA_W-1:0] pc_out;

    modport master (
        output write_en, write_addr, write_data, pc_inc,
        output read_addr_A, read_addr_B, read_addr_C,
        input  read_data_A, read_data_B, read_data_C, pc_out
    );

    modport slave (
        input  write_en, write_addr, write_data, pc_inc,
        input  read_addr_A, read_addr_B, read_addr_C,
        output read_data_A, read_data_B, read_data_C, pc_out
    );

endinterface

// File: rtl/stump_read_port.sv
// -----------------------------------------------------------------------------
// stump_read_port
// Combinational 2**ADDR_W:1 read mux for one register bank read port.
// Address 0 always returns zero. With STUMP_REG_BYPASS_EN defined, a write in
// the same cycle to the addressed (non-zero) register is forwarded.
// Ports:
//   addr       : register select
//   regs       : flattened view of all registers (entry 0 is ignored)
//   write_en   : write strobe        (STUMP_REG_BYPASS_EN only)
//   write_addr : write destination   (STUMP_REG_BYPASS_EN only)
//   write_data : write value         (STUMP_REG_BYPASS_EN only)
//   rd_data    : selected register contents
// -----------------------------------------------------------------------------
module stump_read_port
    import stump_pkg::*;
#(
    parameter int RP_DATA_W = DATA_W,
    parameter int RP_ADDR_W = ADDR_W
) (
    input  logic [RP_ADDR_W-1:0]                     addr,
    input  logic [2**RP_ADDR_W-1:0][RP_DATA_W-1:0]   regs,
`ifdef STUMP_REG_BYPASS_EN
    input  logic                                     write_en,
    input  logic [RP_ADDR_W-1:0]                     write_addr,
    input  logic [RP_DATA_W-1:0]                     write_data,
`endif
    output logic [RP_DATA_W-1:0]                     rd_data
);

    always_comb begin
        rd_data = regs[addr];
`ifdef STUMP_REG_BYPASS_EN
        // Forwarding only looks at the write port, so a pending pc_inc never
        // leaks the incremented PC into a same-cycle read.
        if (write_en && (write_addr == addr))
            rd_data = write_data;
`endif
        // Zero rule last so it overrides forwarding of an R0 write.
        if (addr == RP_ADDR_W'(REG_ZERO))
            rd_data = '0;
    end

endmodule

// File: rtl/stump_reg_bank.sv
// -----------------------------------------------------------------------------
// stump_reg_bank
// Stump register bank: R0 hard-wired to zero, R1..R6 general purpose,
// R7 = program counter with a dedicated fetch increment. Three combinational
// read ports, one synchronous write port. Asynchronous active-low reset.
// Optional macro STUMP_REG_BYPASS_EN enables same-cycle write forwarding on
// the read ports.
// Ports:
//   clk   : system clock, state updates on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : stump_reg_bank_if.slave (write port, pc_inc, read ports, pc_out)
// Parameters:
//   DATA_W, ADDR_W : widths (must match the interface / package)
//   RESET_PC       : value loaded into R7 on reset
// -----------------------------------------------------------------------------
module stump_reg_bank
    import stump_pkg::*;
#(
    parameter int                    BANK_DATA_W = DATA_W,
    parameter int                    BANK_ADDR_W = ADDR_W,
    parameter logic [DATA_W-1:0]     BANK_RESET_PC = RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    stump_reg_bank_if.slave   bus
);

    localparam int NUM_REGS = 2**BANK_ADDR_W;

    // R0 has no storage; R1..R(NUM_REGS-2) are plain registers.
    logic [BANK_DATA_W-1:0] gpr_reg [1:NUM_REGS-2];
    logic [BANK_DATA_W-1:0] pc_reg;

    logic [NUM_REGS-1:0][BANK_DATA_W-1:0] reg_view;
    logic                                 pc_write;

    assign pc_write = bus.write_en && (bus.write_addr == BANK_ADDR_W'(REG_PC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS - 1; i++)
                gpr_reg[i] <= '0;
            pc_reg <= BANK_RESET_PC;
        end else begin
            for (int i = 1; i < NUM_REGS - 1; i++)
                if (bus.write_en && (bus.write_addr == BANK_ADDR_W'(i)))
                    gpr_reg[i] <= bus.write_data;
            // A branch write to R7 beats the fetch increment.
            if (pc_write)
                pc_reg <= bus.write_data;
            else if (bus.pc_inc)
                pc_reg <= pc_reg + BANK_DATA_W'(1);
        end
    end

    always_comb begin
        reg_view = '0;
        for (int i = 1; i < NUM_REGS - 1; i++)
            reg_view[i] = gpr_reg[i];
        reg_view[NUM_REGS-1] = pc_reg;
    end

    assign bus.pc_out = pc_reg;

    // Three identical read ports.
    logic [BANK_ADDR_W-1:0] rd_addr [3];
    logic [BANK_DATA_W-1:0] rd_data [3];

    assign rd_addr[0] = bus.read_addr_A;
    assign rd_addr[1] = bus.read_addr_B;
    assign rd_addr[2] = bus.read_addr_C;

    assign bus.read_data_A = rd_data[0];
    assign bus.read_data_B = rd_data[1];
    assign bus.read_data_C = rd_data[2];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_read_port
            stump_read_port #(
                .RP_DATA_W (BANK_DATA_W),
                .RP_ADDR_W (BANK_ADDR_W)
            ) u_read_port (
                .addr       (rd_addr[gi]),
                .regs       (reg_view),
`ifdef STUMP_REG_BYPASS_EN
                .write_en   (bus.write_en),
                .write_addr (bus.write_addr),
                .write_data (bus.write_data),
`endif
                .rd_data    (rd_data[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_stump_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_stump_reg_bank
// Directed self-checking bench for stump_reg_bank. One line per transaction.
// -----------------------------------------------------------------------------
module tb_stump_reg_bank;

`ifdef STUMP_REG_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    stump_reg_bank_if bus ();

    stump_reg_bank dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        bus.read_addr_A = a;
        bus.read_addr_B = b;
        bus.read_addr_C = c;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [15:0] data);
        bus.write_en   = 1'b1;
        bus.write_addr = addr;
        bus.write_data = data;
        tick();
        bus.write_en   = 1'b0;
        $display("write R%0d <= %h", addr, data);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        bus.write_en   = 1'b0;
        bus.write_addr = '0;
        bus.write_data = '0;
        bus.pc_inc     = 1'b0;
        set_rd(3'd0, 3'd0, 3'd0);

        // Reset asserted; a write held across an edge during reset is lost.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pc_out", bus.pc_out, 16'h0000);
        for (int a = 0; a < 8; a++) begin
            set_rd(3'(a), 3'(a), 3'(a));
            #1;
            chk($sformatf("rst_rd_A_%0d", a), bus.read_data_A, 16'h0000);
        end
        bus.write_en   = 1'b1;
        bus.write_addr = 3'd3;
        bus.write_data = 16'h5555;
        bus.pc_inc     = 1'b1;
        tick();
        bus.write_en = 1'b0;
        bus.pc_inc   = 1'b0;
        set_rd(3'd3, 3'd7, 3'd0);
        #1;
        chk("rst_write_lost", bus.read_data_A, 16'h0000);
        chk("rst_inc_lost", bus.pc_out, 16'h0000);
        $display("reset: write/pc_inc during reset ignored");
        rst_n = 1'b1;

        // Basic writes, then a mid-cycle asynchronous reset.
        wr(3'd3, 16'h1234);
        wr(3'd7, 16'h0042);
        set_rd(3'd3, 3'd7, 3'd3);
        #1;
        chk("r3_written", bus.read_data_A, 16'h1234);
        chk("r7_read_B", bus.read_data_B, 16'h0042);
        chk("pc_out_written", bus.pc_out, 16'h0042);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_r3", bus.read_data_A, 16'h0000);
        chk("async_rst_pc_out", bus.pc_out, 16'h0000);
        chk("async_rst_r7_read", bus.read_data_B, 16'h0000);
        $display("mid-cycle reset: R3 and PC cleared immediately");
        #1 rst_n = 1'b1;
        tick();

        // Write R5, same-cycle and next-cycle reads.
        set_rd(3'd5, 3'd5, 3'd5);
        bus.write_en   = 1'b1;
        bus.write_addr = 3'd5;
        bus.write_data = 16'hBEEF;
        #1;
        chk("r5_same_cycle", bus.read_data_A, BYP ? 16'hBEEF : 16'h0000);
        tick();
        bus.write_en = 1'b0;
        #1;
        chk("r5_A", bus.read_data_A, 16'hBEEF);
        chk("r5_B", bus.read_data_B, 16'hBEEF);
        chk("r5_C", bus.read_data_C, 16'hBEEF);
        $display("write R5 <= beef, read on A/B/C");

        // write_en low: data on the bus must not land.
        bus.write_addr = 3'd5;
        bus.write_data = 16'h0BAD;
        tick();
        chk("no_write_when_disabled", bus.read_data_A, 16'hBEEF);
        $display("write_en=0 with R5 address: no change");

        // R0 write is discarded, now and later.
        set_rd(3'd5, 3'd0, 3'd0);
        bus.write_en   = 1'b1;
        bus.write_addr = 3'd0;
        bus.write_data = 16'hFFFF;
        #1;
        chk("r0_same_cycle", bus.read_data_B, 16'h0000);
        tick();
        bus.write_en = 1'b0;
        chk("r0_next_cycle", bus.read_data_B, 16'h0000);
        tick();
        chk("r0_later_cycle", bus.read_data_C, 16'h0000);
        chk("r5_unaffected", bus.read_data_A, 16'hBEEF);
        $display("write R0 <= ffff discarded");

        // PC wrap through pc_inc.
        wr(3'd7, 16'hFFFE);
        set_rd(3'd7, 3'd7, 3'd7);
        #1;
        chk("pc_preset", bus.pc_out, 16'hFFFE);
        bus.pc_inc = 1'b1;
        #1;
        chk("pc_inc_same_cycle_read", bus.read_data_C, 16'hFFFE);
        tick();
        chk("pc_inc_1", bus.pc_out, 16'hFFFF);
        tick();
        chk("pc_wrap", bus.pc_out, 16'h0000);
        chk("pc_wrap_read_A", bus.read_data_A, 16'h0000);
        bus.pc_inc = 1'b0;
        $display("pc_inc x2 from fffe -> 0000");

        // Branch write beats fetch increment.
        wr(3'd7, 16'h0010);
        chk("pc_0010", bus.pc_out, 16'h0010);
        bus.pc_inc = 1'b1;
        wr(3'd7, 16'h0100);
        bus.pc_inc = 1'b0;
        chk("write_beats_inc", bus.pc_out, 16'h0100);
        $display("write R7 + pc_inc: write wins");

        // pc_inc alongside a write to R2: both happen.
        set_rd(3'd2, 3'd7, 3'd5);
        bus.pc_inc = 1'b1;
        wr(3'd2, 16'h00AA);
        bus.pc_inc = 1'b0;
        chk("parallel_pc", bus.pc_out, 16'h0101);
        chk("parallel_r2", bus.read_data_A, 16'h00AA);
        chk("parallel_r7_read", bus.read_data_B, 16'h0101);
        chk("parallel_r5_kept", bus.read_data_C, 16'hBEEF);
        $display("pc_inc + write R2: both applied");

        // Idle cycle: nothing changes without strobes.
        tick();
        chk("idle_pc_hold", bus.pc_out, 16'h0101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stump_reg_bank.md
Name: stump_reg_bank

Overview:
- Stump register bank: eight 16-bit registers (R0–R7), three combinational read ports and one synchronous write port.
- Sits directly upstream of the 16-bit 2:1 operand multiplexers:
  - read_data_A feeds the ALU A operand.
  - read_data_B feeds the D0 input of the operand-B mux; the immediate feeds D1.
  - read_data_C supplies store data.
- R0 reads as constant zero. R7 is the program counter and also has a dedicated fetch increment.

Parameters:
- DATA_W, 16, register and port data width
- ADDR_W, 3, register address width (2**ADDR_W registers)
- RESET_PC, 16'h0000, value loaded into R7 on reset

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- write_en  input  1  write strobe for the write port
- write_addr  input  ADDR_W  destination register
- write_data  input  DATA_W  data written on the next rising edge when write_en=1
- pc_inc  input  1  fetch-stage request: R7 <= R7+1
- read_addr_A  input  ADDR_W  read port A select
- read_addr_B  input  ADDR_W  read port B select
- read_addr_C  input  ADDR_W  read port C select
- read_data_A  output  DATA_W  contents of read_addr_A
- read_data_B  output  DATA_W  contents of read_addr_B
- read_data_C  output  DATA_W  contents of read_addr_C
- pc_out  output  DATA_W  current R7, to the memory address mux

Behaviour:
- **Reset.** While rst_n=0, asynchronously:
  - R1–R6 clear to 0.
  - R7 loads RESET_PC.
  - Outputs reflect the reset values: pc_out=RESET_PC; read ports show 0, or RESET_PC when addressing 7.
- **Reset release.** Deassertion takes effect on the first rising edge with rst_n=1. A write or pc_inc coincident with an asserted reset is lost.
- **Reads.**
  - Purely combinational, zero latency; a changed read_addr is reflected in the same cycle.
  - Address 0 always returns 16'h0000, independent of any write.
  - All three ports may address the same register simultaneously.
- **Writes.**
  - Take effect on the rising edge with write_en=1.
  - Visible on read ports in the following cycle (no same-cycle bypass unless the optional feature below is enabled).
  - A write to R0 is silently discarded; R0 is not stored.
- **PC increment.**
  - pc_inc=1 gives R7 <= R7+1 on the rising edge.
  - Modulo 2**DATA_W: 16'hFFFF wraps to 16'h0000, with no carry or flag.
- **Simultaneous write and increment.**
  - If write_en=1, write_addr=7 and pc_inc=1 in the same cycle, the write wins: R7 <= write_data and the increment is dropped (branch beats fetch).
  - pc_inc with a write to any other register performs both.
- **No FSM.** State is the register array only; there are no handshake or stall signals. The control unit sequences fetch and execute.

Optional Feature:
- Macro: STUMP_REG_BYPASS_EN
- Defined:
  - Each read port returns write_data when write_en=1, write_addr equals that port's address and the address is non-zero (write-through forwarding, same cycle).
  - Reading address 7 while pc_inc=1 (without a write to R7) still returns the current, un-incremented R7.
- Undefined: reads return stored contents only; written values appear one cycle later.

Decomposition:
- Shared package stump_pkg holds:
  - DATA_W and ADDR_W
  - Register index constants REG_ZERO=3'd0 and REG_PC=3'd7
  - RESET_PC default
- One natural sub-module: stump_read_port, an 8:1 read mux with the R0-zero rule and optional bypass, instantiated three times.

Test Plan:
- **Reset:** assert rst_n=0 mid-cycle with R3=16'h1234 -> R3 reads 0 immediately; pc_out=RESET_PC (16'h0000) without waiting for a clock edge.
- **Write/read:** write R5=16'hBEEF with write_en=1 -> next cycle read_data_A/B/C with addr 5 all = 16'hBEEF; the same-cycle read shows the old value (bypass off) or 16'hBEEF (STUMP_REG_BYPASS_EN).
- **R0:** write R0=16'hFFFF -> read_data_B at addr 0 = 16'h0000 in the same cycle and every later cycle.
- **PC wrap:** write R7=16'hFFFE, then pc_inc for 2 cycles -> pc_out 16'hFFFF, then 16'h0000.
- **Conflict:** R7=16'h0010, write_en=1, write_addr=7, write_data=16'h0100, pc_inc=1 -> pc_out=16'h0100 (not 16'h0101 or 16'h0011).
- **Parallel:** pc_inc=1 with a write of R2=16'h00AA -> both take effect: R7 increments and R2=16'h00AA on the next cycle.
